booth_mac_accumulator: RTL

//  Signed multiply-accumulate back end for the 16x16 Booth multiplier. Consumes the 32-bit
//  two's-complement product z over a valid/ready handshake and sums a vector of products

---
 rtl/booth_mac_accumulator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/booth_mac_accumulator.sv
// Signed multiply-accumulate back end: sums 32-bit products into an ACC_W-bit dot-product.
// Optional feature macro: BOOTH_MAC_SAT_EN (saturating accumulate instead of modular wrap).
module booth_mac_accumulator #(
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned MAX_TERMS = 256,
    localparam int unsigned CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [31:0]      prod,
    input  logic             prod_last,
    input  logic             acc_clr,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             acc_ovf
);

    if (ACC_W < 32) begin : g_acc_w_check
        $error("booth_mac_accumulator: ACC_W must be at least 32");
    end

    typedef enum logic {StAcc, StOut} state_e;

    state_e            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic              beat;
    logic              last_beat;
    logic [ACC_W-1:0]  acc_base;
    logic [CNT_W-1:0]  cnt_base;
    logic              ovf_base;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_new;
    logic [CNT_W-1:0]  cnt_new;
    logic              add_ovf;

    assign beat = prod_valid && prod_ready;

    // A clear in the same cycle as a beat applies first, so the beat starts a fresh vector.
    always_comb begin
        acc_base  = acc;
        cnt_base  = cnt;
        ovf_base  = ovf;
        if (acc_clr) begin
            acc_base = '0;
            cnt_base = '0;
            ovf_base = 1'b0;
        end
        prod_ext  = ACC_W'($signed(prod));
        sum       = acc_base + prod_ext;
        add_ovf   = (acc_base[ACC_W-1] == prod_ext[ACC_W-1]) &&
                    (sum[ACC_W-1] != acc_base[ACC_W-1]);
        cnt_new   = cnt_base + 1'b1;
        last_beat = prod_last || (cnt_base == CNT_W'(MAX_TERMS - 1));
`ifdef BOOTH_MAC_SAT_EN
        if (add_ovf) begin
            // Operand sign tells the overflow direction: negative operands underflow.
            acc_new = acc_base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_new = sum;
        end
`else
        acc_new = sum;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StAcc;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            prod_ready <= 1'b1;
            acc_valid  <= 1'b0;
            acc_out    <= '0;
            term_cnt   <= '0;
            acc_ovf    <= 1'b0;
        end else begin
            unique case (state)
                StAcc: begin
                    if (beat) begin
                        if (last_beat) begin
                            acc_out    <= acc_new;
                            term_cnt   <= cnt_new;
                            acc_ovf    <= ovf_base | add_ovf;
                            acc        <= '0;
                            cnt        <= '0;
                            ovf        <= 1'b0;
                            state      <= StOut;
                            prod_ready <= 1'b0;
                            acc_valid  <= 1'b1;
                        end else begin
                            acc <= acc_new;
                            cnt <= cnt_new;
                            ovf <= ovf_base | add_ovf;
                        end
                    end else if (acc_clr) begin
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end
                end
                StOut: begin
                    if (acc_ready) begin
                        state      <= StAcc;
                        prod_ready <= 1'b1;
                        acc_valid  <= 1'b0;
                    end
                end
                default: begin
                    state <= StAcc;
                end
            endcase
        end
    end

endmodule
